// File: rtl/fp_norm_pkg.sv
// fp_norm_pkg: shared encodings for the normalise/round pipeline.
// Rounding modes, flag bit positions and the exponent bias helper.
package fp_norm_pkg;

   localparam logic [1:0] RND_RNE = 2'd0;
   localparam logic [1:0] RND_RTZ = 2'd1;
   localparam logic [1:0] RND_RUP = 2'd2;
   localparam logic [1:0] RND_RDN = 2'd3;

   localparam int FLG_OVF  = 3;
   localparam int FLG_UF   = 2;
   localparam int FLG_NX   = 1;
   localparam int FLG_ZERO = 0;

   function automatic int fp_bias(input int exp_w);
      return (1 << (exp_w - 1)) - 1;
   endfunction

endpackage

// File: rtl/fp_lzc.sv
// fp_lzc: leading-zero counter, counted from the MSB.
// An all-zero input yields W.
module fp_lzc #(
   parameter  int W     = 48,
   localparam int CNT_W = $clog2(W + 1)
) (
   input  logic [W-1:0]     a_i,
   output logic [CNT_W-1:0] cnt_o
);

   // highest set bit wins because later iterations overwrite
   always_comb begin
      cnt_o = CNT_W'(W);
      for (int i = 0; i < W; i++) begin
         if (a_i[i]) cnt_o = CNT_W'(W - 1 - i);
      end
   end

endmodule

// File: rtl/fp_norm_round_pipe.sv
// fp_norm_round_pipe: 3-stage normalise / round / pack pipeline.
// Stages stall together when the output is held by downstream.
module fp_norm_round_pipe
   import fp_norm_pkg::*;
#(
   parameter int EXP_W = 8,
   parameter int MAN_W = 23,
   parameter int SIG_W = 48,
   parameter int EIN_W = EXP_W + 2
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic                     in_sign,
   input  logic [EIN_W-1:0]         in_exp,
   input  logic [SIG_W-1:0]         in_sig,
   input  logic [1:0]               in_rnd,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [EXP_W+MAN_W:0]     out_result,
   output logic [3:0]               out_flags
);

   localparam int LZ_W  = $clog2(SIG_W + 1);
   localparam int E_W   = EIN_W + 1;
   localparam int RES_W = 1 + EXP_W + MAN_W;
   localparam int GRD   = SIG_W - 2 - MAN_W;
   localparam logic signed [E_W-1:0] E_OVF =
      E_W'(2 * fp_bias(EXP_W) + 1);
   localparam logic [SIG_W-2:0] STK_M =
      {(SIG_W-1){1'b1}} >> (SIG_W - GRD);

   logic adv;

   logic v1_q, v2_q, v3_q;

   logic                s1_sign_q, s1_zero_q;
   logic [1:0]          s1_rnd_q;
   logic [E_W-1:0]      s1_e_q;
   logic [SIG_W-2:0]    s1_frac_q;

   logic                s2_sign_q, s2_zero_q, s2_nx_q;
   logic [1:0]          s2_rnd_q;
   logic signed [E_W-1:0] s2_e_q;
   logic [MAN_W-1:0]    s2_man_q;

   logic [RES_W-1:0]    res_q;
   logic [3:0]          flg_q;

   logic [LZ_W-1:0]     lzc;
   logic [SIG_W-1:0]    shl;
   logic [E_W-1:0]      s1_e_d;
   logic                s1_zero_d;

   logic [MAN_W-1:0]    man;
   logic                g, r, st, nx, inc;
   logic [MAN_W:0]      man_sum;
   logic [MAN_W-1:0]    s2_man_d;
   logic [E_W-1:0]      s2_e_d;

   logic                to_inf;
   logic [RES_W-1:0]    res_d;
   logic [3:0]          flg_d;

   assign adv        = ~(v3_q & ~out_ready);
   assign in_ready   = adv;
   assign out_valid  = v3_q;
   assign out_result = res_q;
   assign out_flags  = flg_q;

   fp_lzc #(.W(SIG_W)) u_lzc (
      .a_i   (in_sig),
      .cnt_o (lzc)
   );

   // S1 next state: shift leading 1 to the top, rebase exponent
   always_comb begin
      shl       = in_sig << lzc;
      s1_zero_d = ~shl[SIG_W-1];
      s1_e_d    = {in_exp[EIN_W-1], in_exp} + E_W'(1) - E_W'(lzc);
   end

   // S2 next state: pick mantissa/g/r/s and apply rounding increment
   always_comb begin
      man  = s1_frac_q[SIG_W-2 -: MAN_W];
      g    = s1_frac_q[GRD];
      r    = s1_frac_q[GRD-1];
      st   = |(s1_frac_q & STK_M);
      nx   = g | r | st;
      inc  = 1'b0;
      unique case (s1_rnd_q)
         RND_RNE: inc = g & (r | st | man[0]);
         RND_RTZ: inc = 1'b0;
         RND_RUP: inc = nx & ~s1_sign_q;
         RND_RDN: inc = nx & s1_sign_q;
      endcase
      man_sum  = {1'b0, man} + {{MAN_W{1'b0}}, inc};
      s2_man_d = man_sum[MAN_W-1:0];
      s2_e_d   = s1_e_q + E_W'(man_sum[MAN_W]);
   end

   // S3 next state: zero, overflow, underflow or normal packing
   always_comb begin
      to_inf = (s2_rnd_q == RND_RNE)
             | ((s2_rnd_q == RND_RUP) & ~s2_sign_q)
             | ((s2_rnd_q == RND_RDN) & s2_sign_q);
      res_d  = {s2_sign_q, s2_e_q[EXP_W-1:0], s2_man_q};
      flg_d  = '0;
      flg_d[FLG_NX] = s2_nx_q;
      if (s2_zero_q) begin
         res_d = {s2_sign_q, {(RES_W-1){1'b0}}};
         flg_d = '0;
         flg_d[FLG_ZERO] = 1'b1;
      end else if (s2_e_q >= E_OVF) begin
         res_d = to_inf
               ? {s2_sign_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}}
               : {s2_sign_q, {(EXP_W-1){1'b1}}, 1'b0,
                  {MAN_W{1'b1}}};
         flg_d[FLG_OVF] = 1'b1;
         flg_d[FLG_NX]  = 1'b1;
      end else if (s2_e_q[E_W-1] | (s2_e_q == '0)) begin
         res_d = {s2_sign_q, {(RES_W-1){1'b0}}};
         flg_d[FLG_UF]   = 1'b1;
         flg_d[FLG_NX]   = 1'b1;
         flg_d[FLG_ZERO] = 1'b1;
      end
   end

   // stage valid bits; bubbles move whenever the output is not held
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         v1_q <= 1'b0;
         v2_q <= 1'b0;
         v3_q <= 1'b0;
      end else if (adv) begin
         v1_q <= in_valid;
         v2_q <= v1_q;
         v3_q <= v2_q;
      end
   end

   // S1 register: normalised fraction and exponent
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_sign_q <= 1'b0;
         s1_zero_q <= 1'b0;
         s1_rnd_q  <= '0;
         s1_e_q    <= '0;
         s1_frac_q <= '0;
      end else if (adv) begin
         s1_sign_q <= in_sign;
         s1_zero_q <= s1_zero_d;
         s1_rnd_q  <= in_rnd;
         s1_e_q    <= s1_e_d;
         s1_frac_q <= shl[SIG_W-2:0];
      end
   end

   // S2 register: rounded mantissa and adjusted exponent
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s2_sign_q <= 1'b0;
         s2_zero_q <= 1'b0;
         s2_nx_q   <= 1'b0;
         s2_rnd_q  <= '0;
         s2_e_q    <= '0;
         s2_man_q  <= '0;
      end else if (adv) begin
         s2_sign_q <= s1_sign_q;
         s2_zero_q <= s1_zero_q;
         s2_nx_q   <= nx;
         s2_rnd_q  <= s1_rnd_q;
         s2_e_q    <= s2_e_d;
         s2_man_q  <= s2_man_d;
      end
   end

   // S3 register: packed result and flags held while stalled
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         res_q <= '0;
         flg_q <= '0;
      end else if (adv) begin
         res_q <= res_d;
         flg_q <= flg_d;
      end
   end

endmodule
